// File: rtl/alu_pkg.sv
// Shared types for the ALU execute stage: op codes, FSM states, shift classifier
// and the default datapath width.
package alu_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_BEQ  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_BNE  = 4'b0101,
    OP_SUB  = 4'b0110,
    OP_BLT  = 4'b0111,
    OP_SRL  = 4'b1000,
    OP_SRA  = 4'b1001,
    OP_SLL  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_SLT  = 4'b1100,
    OP_SLTU = 4'b1101,
    OP_BLTU = 4'b1110,
    OP_BGEU = 4'b1111
  } alu_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } alu_state_e;

  function automatic logic is_shift(alu_op_e op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_SLL);
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative shifter: one bit position per cycle. i_start loads the operand and
// a non-zero shift count; o_done is high during the final step, with o_result
// carrying the value that step produces.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_start,
  input  alu_op_e                       i_op,
  input  logic [DATA_WIDTH-1:0]         i_value,
  input  logic [$clog2(DATA_WIDTH)-1:0] i_shamt,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [DATA_WIDTH-1:0]         o_result
);

  localparam int unsigned SW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] r_value;
  logic [SW-1:0]         r_count;
  alu_op_e               r_op;
  logic [DATA_WIDTH-1:0] w_step;

  // One-bit shift of the working value; SRA replicates the sign bit
  always_comb begin
    case (r_op)
      OP_SRA:  w_step = {r_value[DATA_WIDTH-1], r_value[DATA_WIDTH-1:1]};
      OP_SLL:  w_step = {r_value[DATA_WIDTH-2:0], 1'b0};
      default: w_step = {1'b0, r_value[DATA_WIDTH-1:1]};
    endcase
  end

  // Operand/count load on start, then shift and count down until zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_count <= '0;
      r_op    <= OP_SRL;
    end else if (i_start) begin
      r_value <= i_value;
      r_count <= i_shamt;
      r_op    <= i_op;
    end else if (r_count != '0) begin
      r_value <= w_step;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_busy   = (r_count != '0);
  assign o_done   = (r_count == SW'(1));
  assign o_result = w_step;

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage with valid/ready on both sides and a registered result.
// Build option: ALU_BARREL_SHIFT_EN selects a single-cycle barrel shifter;
// otherwise shifts by N>0 run iteratively through alu_shift_iter (latency N+1).
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  localparam int unsigned SW = $clog2(DATA_WIDTH);

  alu_op_e               w_op;
  logic [SW-1:0]         w_shamt;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_alu_res;
  logic [DATA_WIDTH-1:0] w_load_val;
  logic                  w_load;
  logic                  w_valid_nxt;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_zero;

  assign w_op     = alu_op_e'(operation);
  assign w_shamt  = src_b[SW-1:0];
  assign w_accept = in_valid && in_ready;

  // Single-cycle datapath; compares and branches yield the flag in bit 0
  always_comb begin
    w_alu_res = '0;
    case (w_op)
      OP_AND:         w_alu_res = src_a & src_b;
      OP_OR:          w_alu_res = src_a | src_b;
      OP_XOR:         w_alu_res = src_a ^ src_b;
      OP_ADD:         w_alu_res = src_a + src_b;
      OP_SUB:         w_alu_res = src_a - src_b;
      OP_BEQ:         w_alu_res[0] = (src_a == src_b);
      OP_BNE:         w_alu_res[0] = (src_a != src_b);
      OP_BLT, OP_SLT: w_alu_res[0] = ($signed(src_a) < $signed(src_b));
      OP_BGE:         w_alu_res[0] = ($signed(src_a) >= $signed(src_b));
      OP_SLTU,
      OP_BLTU:        w_alu_res[0] = (src_a < src_b);
      OP_BGEU:        w_alu_res[0] = (src_a >= src_b);
`ifdef ALU_BARREL_SHIFT_EN
      OP_SRL:         w_alu_res = src_a >> w_shamt;
      OP_SRA:         w_alu_res = DATA_WIDTH'($signed(src_a) >>> w_shamt);
      OP_SLL:         w_alu_res = src_a << w_shamt;
`else
      // Only reached for a zero shift amount; non-zero amounts go iterative
      OP_SRL, OP_SRA,
      OP_SLL:         w_alu_res = src_a;
`endif
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN

  assign in_ready = !r_out_valid || out_ready;

  // Every op completes in one cycle: load on accept, else hold until consumed
  always_comb begin
    w_load      = w_accept;
    w_load_val  = w_alu_res;
    w_valid_nxt = w_accept || (r_out_valid && !out_ready);
  end

`else

  alu_state_e            r_state;
  alu_state_e            w_state_nxt;
  logic                  w_sh_start;
  logic                  w_sh_busy;
  logic                  w_sh_done;
  logic [DATA_WIDTH-1:0] w_sh_res;

  alu_shift_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_sh_start),
    .i_op     (w_op),
    .i_value  (src_a),
    .i_shamt  (w_shamt),
    .o_busy   (w_sh_busy),
    .o_done   (w_sh_done),
    .o_result (w_sh_res)
  );

  assign in_ready = (r_state == ST_IDLE) && !w_sh_busy && (!r_out_valid || out_ready);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, shifter start and result-load control
  always_comb begin
    w_state_nxt = r_state;
    w_sh_start  = 1'b0;
    w_load      = 1'b0;
    w_load_val  = w_alu_res;
    w_valid_nxt = r_out_valid && !out_ready;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (is_shift(w_op) && (w_shamt != '0)) begin
            w_sh_start  = 1'b1;
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_SHIFT;
          end else begin
            w_load      = 1'b1;
            w_valid_nxt = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (w_sh_done) begin
          w_load      = 1'b1;
          w_load_val  = w_sh_res;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`endif

  // Output registers: result and zero flag load together, valid tracks handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
    end else begin
      r_out_valid <= w_valid_nxt;
      if (w_load) begin
        r_result <= w_load_val;
        r_zero   <= (w_load_val == '0);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the driver queues hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_exec_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  operation;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb[$];

  alu_exec_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output monitor: a transfer happens at the next posedge when valid && ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual=%h required=none", result);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("result", result, e);
        chk("zero", {31'b0, zero}, {31'b0, (e == 32'h0)});
      end
    end
  end

  // Present one op and hold it until accepted; call away from the posedge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input logic push, output int waits);
    if (push) sb.push_back(exp);
    in_valid  = 1'b1;
    operation = op;
    src_a     = a;
    src_b     = b;
    waits     = 0;
    @(negedge clk);
    while (!in_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=stalled required=in_ready");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Edges from the accept edge (inclusive) until out_valid; counts in_ready highs
  task automatic wait_valid(output int lat, output int rdy_seen);
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, BEQ = 4'b0011;
  localparam logic [3:0] XOR_ = 4'b0100, BNE = 4'b0101, SUB = 4'b0110, BLT = 4'b0111;
  localparam logic [3:0] SRL = 4'b1000, SRA = 4'b1001, SLL = 4'b1010, BGE = 4'b1011;
  localparam logic [3:0] SLT = 4'b1100, SLTU = 4'b1101, BLTU = 4'b1110, BGEU = 4'b1111;

`ifdef ALU_BARREL_SHIFT_EN
  localparam int SRA31_LAT = 1;
  localparam logic KILLED_PUSH = 1'b1;
`else
  localparam int SRA31_LAT = 32;
  localparam logic KILLED_PUSH = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t cmp_vecs[$] = '{
    '{SLT,  32'hFFFFFFFF, 32'h1, 32'h1},
    '{SLTU, 32'hFFFFFFFF, 32'h1, 32'h0},
    '{BGEU, 32'h3,        32'h3, 32'h1},
    '{BNE,  32'h4,        32'h4, 32'h0},
    '{BEQ,  32'h4,        32'h4, 32'h1},
    '{BLT,  32'hFFFFFFFB, 32'h3, 32'h1},
    '{BGE,  32'hFFFFFFFB, 32'h3, 32'h0},
    '{BLTU, 32'hFFFFFFFF, 32'h1, 32'h0},
    '{SLL,  32'h00000001, 32'h0, 32'h1},
    '{SLL,  32'h00000003, 32'h4, 32'h30}
  };

  vec_t stream_vecs[$] = '{
    '{ADD,  32'h1,        32'h2,        32'h3},
    '{AND_, 32'hF0F0,     32'h0FF0,     32'h00F0},
    '{OR_,  32'h0F00,     32'h00F0,     32'h0FF0},
    '{ADD,  32'h10,       32'h20,       32'h30},
    '{AND_, 32'hFFFF0000, 32'h12345678, 32'h12340000},
    '{OR_,  32'h0,        32'h0,        32'h0},
    '{ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000},
    '{AND_, 32'hAAAAAAAA, 32'h55555555, 32'h0}
  };

  initial begin
    int w;
    int lat;
    int rdy;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    operation = 4'h0;
    src_a     = '0;
    src_b     = '0;

    // Reset values, then in_ready right after release
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Asynchronous reset in the middle of SLL by 20
    send(SLL, 32'h1, 32'd20, 32'h00100000, KILLED_PUSH, w);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midshift_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midshift_result", result, 32'h0);
    chk("midshift_zero", {31'b0, zero}, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Wrapping arithmetic with single-cycle latency
    send(ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b1, w);
    wait_valid(lat, rdy);
    chk("add_latency", lat, 1);
    send(SUB, 32'h5, 32'h7, 32'hFFFFFFFE, 1'b1, w);
    wait_valid(lat, rdy);
    chk("sub_latency", lat, 1);

    // Compares, branches and short shifts
    foreach (cmp_vecs[i]) begin
      send(cmp_vecs[i].op, cmp_vecs[i].a, cmp_vecs[i].b, cmp_vecs[i].exp, 1'b1, w);
    end
    wait_valid(lat, rdy);

    // Long shifts: latency and blocked input
    send(SRA, 32'h80000000, 32'd31, 32'hFFFFFFFF, 1'b1, w);
    wait_valid(lat, rdy);
    chk("sra31_latency", lat, SRA31_LAT);
    chk("sra31_in_ready_busy", rdy, 0);
    send(SRL, 32'h80000000, 32'd31, 32'h00000001, 1'b1, w);
    wait_valid(lat, rdy);
    chk("srl31_latency", lat, SRA31_LAT);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result held three cycles, next op taken on release
    out_ready = 1'b0;
    send(XOR_, 32'hF0, 32'hFF, 32'h0F, 1'b1, w);
    sb.push_back(32'h4);
    in_valid  = 1'b1;
    operation = ADD;
    src_a     = 32'h2;
    src_b     = 32'h2;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_result", result, 32'h0F);
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_swap_out_valid", {31'b0, out_valid}, 32'h1);

    // Streaming: one op per cycle with no stalls
    foreach (stream_vecs[i]) begin
      send(stream_vecs[i].op, stream_vecs[i].a, stream_vecs[i].b, stream_vecs[i].exp, 1'b1, w);
      chk("stream_stall", w, 0);
    end

    // Drain the scoreboard
    for (int unsigned k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
